// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 decoder front-end.
package lz77_pkg;

    localparam logic [7:0] TERM_CHAR    = 8'h24;
    localparam int         SEARCH_DEPTH = 9;

    typedef struct packed {
        logic [3:0] pos;
        logic [2:0] len;
        logic [7:0] chr;
    } token_t;

    localparam int TOKEN_W = $bits(token_t);

    typedef enum logic [1:0] {WAIT, RUN, DRAIN, DONE} state_t;

endpackage

// File: rtl/lz77_tok_fifo.sv
// Token FIFO with occupancy outputs and a scan that reports whether any
// buffered token carries the terminator character.
module lz77_tok_fifo import lz77_pkg::*; #(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] MATCH_CHAR = 8'h24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [TOKEN_W-1:0]       din,
    input  logic                     pop,
    output logic [TOKEN_W-1:0]       head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     term_seen
);

    localparam int AW = $clog2(DEPTH);

    token_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= token_t'(din);
    end

    // Only slots inside the live window [rd_ptr, rd_ptr+cnt) are considered.
    always_comb begin
        term_seen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < cnt) && (mem[rd_ptr + AW'(i)].chr == MATCH_CHAR))
                term_seen = 1'b1;
        end
    end

endmodule

// File: rtl/lz77_dec_sequencer.sv
// Feeds buffered LZ77 tokens to the free-running decoder, holding each for
// len+1 cycles, and tags/counts the decoded characters.
module lz77_dec_sequencer import lz77_pkg::*; #(
    parameter int         DEPTH        = 4,
    parameter int         START_THRESH = 2,
    parameter logic [7:0] TERM_CHAR    = lz77_pkg::TERM_CHAR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic [3:0]  tok_pos,
    input  logic [2:0]  tok_len,
    input  logic [7:0]  tok_char,
    output logic        dec_reset,
    output logic [3:0]  dec_code_pos,
    output logic [2:0]  dec_code_len,
    output logic [7:0]  dec_chardata,
    input  logic        dec_finish,
    input  logic [7:0]  dec_char_nxt,
    output logic        out_valid,
    output logic [7:0]  out_char,
    output logic [15:0] char_count,
    output logic        done,
    output logic        underrun
);

    localparam int AW = $clog2(DEPTH);

    state_t             state;
    token_t             hold;
    logic [2:0]         cyc;
    logic               live;
    logic [TOKEN_W-1:0] head;
    logic               full, empty, term_seen;
    logic [AW:0]        count;
    logic               push, pop, go, boundary, finish_now, flush, issue;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign tok_ready    = live && !full && (state != DONE);
    assign dec_code_pos = hold.pos;
    assign dec_code_len = hold.len;
    assign dec_chardata = hold.chr;

    always_comb begin
        push       = tok_valid && tok_ready;
        go         = (state == WAIT) && ((int'(count) >= START_THRESH) || term_seen);
        boundary   = (state == RUN) && (cyc == hold.len);
        finish_now = dec_finish && ((state == RUN) || (state == DRAIN));
        pop        = go || (boundary && !empty && !finish_now);
        flush      = finish_now || (state == DRAIN);
        // Once the decoder reports finish its output is no longer a stream char.
        issue      = (state == RUN) && !dec_finish;
    end

    lz77_tok_fifo #(.DEPTH(DEPTH), .MATCH_CHAR(TERM_CHAR)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .din       ({tok_pos, tok_len, tok_char}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .term_seen (term_seen)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT;
            hold       <= '0;
            cyc        <= '0;
            live       <= 1'b0;
            dec_reset  <= 1'b1;
            out_valid  <= 1'b0;
            out_char   <= '0;
            char_count <= '0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            live      <= 1'b1;
            out_valid <= issue;
            if (issue)     out_char   <= dec_char_nxt;
            if (out_valid) char_count <= sat_inc(char_count);
            case (state)
                WAIT: if (go) begin
                    hold      <= token_t'(head);
                    cyc       <= '0;
                    state     <= RUN;
                    dec_reset <= 1'b0;
                end
                RUN: begin
                    if (finish_now) begin
                        done      <= 1'b1;
                        state     <= DONE;
                        dec_reset <= 1'b1;
                    end else if (boundary) begin
                        if (!empty) begin
                            hold <= token_t'(head);
                            cyc  <= '0;
                        end else if (hold.chr == TERM_CHAR) begin
                            state     <= DRAIN;
                            dec_reset <= 1'b1;
                        end else begin
                            // Starved: keep the token held and cyc parked on
                            // the boundary so the pop is retried each cycle.
                            underrun <= 1'b1;
                        end
                    end else begin
                        cyc <= cyc + 3'd1;
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    dec_reset <= 1'b1;
                    done      <= 1'b1;
                    if (!dec_finish) underrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_dec_sequencer.sv
// Bench for lz77_dec_sequencer: behavioural decoder stub plus a queue-based
// LZ77 reference for the expected character stream and issue trace.
module tb_lz77_dec_sequencer;
    import lz77_pkg::*;

    localparam logic [7:0] TERM = 8'h24;

    logic        clk = 1'b0;
    logic        reset;
    logic        tok_valid;
    logic        tok_ready;
    logic [3:0]  tok_pos;
    logic [2:0]  tok_len;
    logic [7:0]  tok_char;
    logic        dec_reset;
    logic [3:0]  dec_code_pos;
    logic [2:0]  dec_code_len;
    logic [7:0]  dec_chardata;
    logic        dec_finish = 1'b0;
    logic [7:0]  dec_char_nxt = 8'h00;
    logic        out_valid;
    logic [7:0]  out_char;
    logic [15:0] char_count;
    logic        done;
    logic        underrun;

    always #5 clk = ~clk;

    lz77_dec_sequencer #(.DEPTH(4), .START_THRESH(2), .TERM_CHAR(TERM)) dut (
        .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_pos(tok_pos), .tok_len(tok_len), .tok_char(tok_char),
        .dec_reset(dec_reset), .dec_code_pos(dec_code_pos), .dec_code_len(dec_code_len),
        .dec_chardata(dec_chardata), .dec_finish(dec_finish), .dec_char_nxt(dec_char_nxt),
        .out_valid(out_valid), .out_char(out_char), .char_count(char_count),
        .done(done), .underrun(underrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decoder stub: copies from its own history for len cycles, then emits the literal.
    logic [7:0] dhist[$];
    int         dk = 0;

    function automatic logic [7:0] dec_char();
        int idx;
        if (dk < int'(dec_code_len)) begin
            idx = dhist.size() - 1 - int'(dec_code_pos);
            return (idx >= 0) ? dhist[idx] : 8'h00;
        end
        return dec_chardata;
    endfunction

    always @(posedge clk) begin
        if (dec_reset) begin
            dhist.delete();
            dk = 0;
            dec_finish <= 1'b0;
        end else begin
            dhist.push_back(dec_char_nxt);
            if (dk >= int'(dec_code_len)) begin
                if (dec_char_nxt == TERM) dec_finish <= 1'b1;
                dk = 0;
            end else begin
                dk++;
            end
        end
    end

    always @(negedge clk) dec_char_nxt = dec_char();

    function automatic token_t snap();
        return token_t'({dec_code_pos, dec_code_len, dec_chardata});
    endfunction

    logic [7:0] got[$];
    token_t     trace[$];
    always @(negedge clk) begin
        if (out_valid)  got.push_back(out_char);
        if (!dec_reset) trace.push_back(snap());
    end

    token_t     toks[$];
    logic [7:0] exp_chars[$];
    token_t     exp_trace[$];

    task automatic build_expected();
        exp_chars.delete();
        exp_trace.delete();
        foreach (toks[i]) begin
            for (int k = 0; k < int'(toks[i].len); k++) begin
                int idx;
                idx = exp_chars.size() - 1 - int'(toks[i].pos);
                exp_chars.push_back((idx >= 0) ? exp_chars[idx] : 8'h00);
            end
            exp_chars.push_back(toks[i].chr);
            for (int k = 0; k <= int'(toks[i].len); k++) exp_trace.push_back(toks[i]);
        end
    endtask

    int   max_wait;
    logic stall_pending;
    logic stall_load;

    task automatic push_tok(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        int     w;
        token_t prev, cur;
        w = 0;
        tok_valid = 1'b1; tok_pos = p; tok_len = l; tok_char = c;
        @(negedge clk);
        cur = snap();
        prev = cur;
        while (!tok_ready && w < 200) begin
            prev = cur;
            w++;
            @(negedge clk);
            cur = snap();
        end
        check("push_accept", tok_ready, 1'b1);
        if (w > max_wait) max_wait = w;
        if (w > 0 && stall_pending) begin
            stall_pending = 1'b0;
            stall_load    = (cur != prev);
        end
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        toks.push_back(token_t'({p, l, c}));
    endtask

    task automatic do_reset();
        tok_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        toks.delete();
        got.delete();
        trace.delete();
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!done && w < 600) begin
            @(negedge clk);
            w++;
        end
        check("done_reached", done, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        int n;
        build_expected();
        check({tag, "_nchars"}, got.size(), exp_chars.size());
        n = (got.size() < exp_chars.size()) ? got.size() : exp_chars.size();
        for (int i = 0; i < n; i++) check({tag, "_char"}, got[i], exp_chars[i]);
        check({tag, "_ntrace"}, trace.size(), exp_trace.size());
        n = (trace.size() < exp_trace.size()) ? trace.size() : exp_trace.size();
        for (int i = 0; i < n; i++) check({tag, "_issue"}, trace[i], exp_trace[i]);
        check({tag, "_count"}, char_count, exp_chars.size());
        check({tag, "_underrun"}, underrun, 1'b0);
        check({tag, "_parked"}, dec_reset, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tok_ready"}, tok_ready, 1'b0);
        check({tag, "_dec_reset"}, dec_reset, 1'b1);
        check({tag, "_dec_code"}, {dec_code_pos, dec_code_len, dec_chardata}, 15'd0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_char"}, out_char, 8'h00);
        check({tag, "_count"}, char_count, 16'd0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_underrun"}, underrun, 1'b0);
    endtask

    initial begin
        logic [47:0] seq;
        logic [47:0] want;
        token_t      held;
        int          run, last;

        reset = 1'b1; tok_valid = 1'b0; tok_pos = '0; tok_len = '0; tok_char = '0;
        max_wait = 0; stall_pending = 1'b0; stall_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        toks.delete(); got.delete(); trace.delete();

        // Basic stream a, b, then a 3-char match plus terminator.
        push_tok(4'd0, 3'd0, "a");
        check("held_one_token", dec_reset, 1'b1);
        push_tok(4'd0, 3'd0, "b");
        push_tok(4'd1, 3'd3, TERM);
        check("released", dec_reset, 1'b0);
        wait_done();
        check_stream("basic");
        seq = '0;
        foreach (got[i]) seq = {seq[39:0], got[i]};
        want = "ababa$";
        check("basic_seq", seq, want);
        check("basic_done", done, 1'b1);

        // Long token is held for len+1 cycles and followed directly by the next.
        do_reset();
        push_tok(4'd0, 3'd0, "a");
        push_tok(4'd0, 3'd0, "b");
        push_tok(4'd2, 3'd7, "x");
        push_tok(4'd0, 3'd0, TERM);
        wait_done();
        check_stream("hold8");
        run = 0; last = -1;
        foreach (trace[i]) if (trace[i] == token_t'({4'd2, 3'd7, 8'h78})) begin run++; last = i; end
        check("hold8_run", run, 8);
        if (last >= 0 && last + 1 < trace.size())
            check("hold8_next", trace[last+1], token_t'({4'd0, 3'd0, TERM}));
        else
            check("hold8_next_present", last + 1, trace.size() - 1);

        // Back-pressure with long tokens and a continuously valid upstream.
        do_reset();
        push_tok(4'd0, 3'd7, "A");
        max_wait = 0; stall_pending = 1'b1; stall_load = 1'b0;
        for (int i = 1; i < 6; i++) push_tok(4'(i % 2), 3'd7, 8'(8'h41 + i));
        push_tok(4'd1, 3'd2, TERM);
        wait_done();
        check("full_backpressure", (max_wait > 0), 1'b1);
        check("ready_on_pop", stall_load, 1'b1);
        check_stream("full");

        // Upstream stall after a short token: underrun, hold, then resume.
        do_reset();
        push_tok(4'd0, 3'd0, "p");
        push_tok(4'd0, 3'd0, "q");
        repeat (6) @(negedge clk);
        check("stall_underrun", underrun, 1'b1);
        held = snap();
        check("stall_held_q", held, token_t'({4'd0, 3'd0, 8'h71}));
        repeat (4) @(negedge clk);
        check("stall_unchanged", snap(), token_t'({4'd0, 3'd0, 8'h71}));
        check("stall_running", dec_reset, 1'b0);
        push_tok(4'd0, 3'd0, TERM);
        wait_done();
        check("stall_resumed", dec_chardata, TERM);
        check("stall_sticky", underrun, 1'b1);

        // One-cycle reset in the middle of a stream.
        do_reset();
        push_tok(4'd0, 3'd1, "m");
        push_tok(4'd0, 3'd7, "n");
        push_tok(4'd0, 3'd7, "o");
        push_tok(4'd0, 3'd7, "r");
        repeat (3) @(posedge clk);
        #1;
        check("midrun_active", dec_reset, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        reset = 1'b0;
        toks.delete(); got.delete(); trace.delete();
        push_tok(4'd0, 3'd0, TERM);
        wait_done();
        check_stream("after_rst");

        // Tokens offered after done are refused.
        tok_valid = 1'b1; tok_pos = 4'd0; tok_len = 3'd0; tok_char = "z";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_done_ready", tok_ready, 1'b0);
            check("post_done_count", char_count, 16'd1);
            check("post_done_parked", dec_reset, 1'b1);
        end
        tok_valid = 1'b0;

        // Random streams ending in a terminator.
        for (int it = 0; it < 4; it++) begin
            int n;
            do_reset();
            n = $urandom_range(3, 10);
            for (int i = 0; i < n; i++)
                push_tok(4'($urandom_range(0, 8)), 3'($urandom_range(0, 7)),
                         8'($urandom_range(8'h30, 8'h7a)));
            push_tok(4'($urandom_range(0, 8)), 3'($urandom_range(0, 7)), TERM);
            wait_done();
            check_stream("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
